// File: rtl/debounce_fsm.sv
// Purpose: debounces a raw switch level into a clean level plus one-cycle rise/fall pulses.
// Latency: a change is accepted after 2 sync flops, WAIT entry, then StableTicks sample ticks.
// Backpressure: none; the block free-runs and its outputs are always valid.
module debounce_fsm #(
    parameter int TickWidth   = 19,
    parameter int StableTicks = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic db_level_o,
    output logic db_rise_o,
    output logic db_fall_o
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [3:0] CntLast = 4'(StableTicks - 1);

    logic                 sw_meta;
    logic                 sw_s;
    logic [TickWidth-1:0] tick_cnt;
    logic                 tick;
    state_t               state_q;
    state_t               state_d;
    logic [3:0]           cnt_q;
    logic [3:0]           cnt_d;
    logic                 level_d;

    // Two-flop synchronizer; only the second stage feeds the FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_meta <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sw_meta <= sw_i;
            sw_s    <= sw_meta;
        end
    end

    // Free-running sample-tick counter, never restarted by FSM activity.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = &tick_cnt;

    // State and stable-count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ZERO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: a reversal of sw_s always wins over tick counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ZERO: begin
                if (sw_s) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_d = ZERO;
                end else if (tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = ONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_d = ONE;
                end else if (tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = ZERO;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == ONE) || (state_d == WAIT0);
    end

    // Output registers track the state register; edges compare against the held level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            db_level_o <= 1'b0;
            db_rise_o  <= 1'b0;
            db_fall_o  <= 1'b0;
        end else begin
            db_level_o <= level_d;
            db_rise_o  <= level_d & ~db_level_o;
            db_fall_o  <= ~level_d & db_level_o;
        end
    end

endmodule

// File: tb/tb_debounce_fsm.sv
// Purpose: randomized and directed checks of debounce_fsm against a run-length reference model.
// Latency: the model predicts outputs for each clock edge; outputs are sampled 1 time unit later.
// Backpressure: none; stimulus is a plain level on sw_i.
module tb_debounce_fsm;

    localparam int TW     = 3;
    localparam int STABLE = 3;
    localparam int PERIOD = 1 << TW;
    localparam int LAT_MIN = (STABLE - 1) * PERIOD + 3;
    localparam int LAT_MAX = STABLE * PERIOD + 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic sw_i  = 1'b0;
    logic db_level_o;
    logic db_rise_o;
    logic db_fall_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: sync pipeline, tick phase, accepted level, pending run.
    bit m_s1, m_s2;
    int m_tc;
    bit m_lvl, m_pend;
    int m_ticks;
    bit e_rise, e_fall;

    debounce_fsm #(.TickWidth(TW), .StableTicks(STABLE)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sw_i       (sw_i),
        .db_level_o (db_level_o),
        .db_rise_o  (db_rise_o),
        .db_fall_o  (db_fall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_tc = 0;
        m_lvl = 0; m_pend = 0; m_ticks = 0;
        e_rise = 0; e_fall = 0;
    endtask

    // A new level is accepted once the synced input has disagreed with it for a
    // run that spans STABLE sample ticks after the run was first noticed.
    task automatic model_edge(input bit sw);
        bit ss, tk, old;
        ss = m_s2;
        tk = (m_tc == PERIOD - 1);
        old = m_lvl;
        m_s2 = m_s1;
        m_s1 = sw;
        m_tc = (m_tc + 1) % PERIOD;
        if (ss == m_lvl) begin
            m_pend = 0;
        end else if (!m_pend) begin
            m_pend = 1;
            m_ticks = 0;
        end else if (tk) begin
            m_ticks++;
            if (m_ticks == STABLE) begin
                m_lvl = !m_lvl;
                m_pend = 0;
            end
        end
        e_rise = m_lvl && !old;
        e_fall = !m_lvl && old;
    endtask

    // Drive one level for one clock and advance the model across that edge.
    task automatic drive(input bit sw);
        sw_i = sw;
        @(posedge clk_i);
        #1;
        model_edge(sw);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        sw_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_vec++;
        if ({db_level_o, db_rise_o, db_fall_o} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000", {db_level_o, db_rise_o, db_fall_o});
        end
        #3 rst_i = 1'b0;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b0);
            n_vec++;
            if ({db_level_o, db_rise_o, db_fall_o} !== {m_lvl, e_rise, e_fall}) begin
                n_err++;
                $display("FAIL idle_zero cyc %0d: got %b want %b", i,
                         {db_level_o, db_rise_o, db_fall_o}, {m_lvl, e_rise, e_fall});
            end
        end
        n_vec++;
        if (db_level_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_level: got %b want 0", db_level_o);
        end
    endtask

    task automatic test_rise();
        int rises = 0;
        int first = -1;
        for (int i = 1; i <= 40; i++) begin
            drive(1'b1);
            n_vec++;
            if ({db_level_o, db_rise_o, db_fall_o} !== {m_lvl, e_rise, e_fall}) begin
                n_err++;
                $display("FAIL rise_model cyc %0d: got %b want %b", i,
                         {db_level_o, db_rise_o, db_fall_o}, {m_lvl, e_rise, e_fall});
            end
            if (db_rise_o === 1'b1) begin
                rises++;
                if (first < 0) first = i;
            end
        end
        n_vec++;
        if (rises != 1) begin
            n_err++;
            $display("FAIL rise_count: got %0d want 1", rises);
        end
        n_vec++;
        if (first < LAT_MIN || first > LAT_MAX) begin
            n_err++;
            $display("FAIL rise_latency: got %0d want %0d..%0d", first, LAT_MIN, LAT_MAX);
        end
        n_vec++;
        if (db_level_o !== 1'b1) begin
            n_err++;
            $display("FAIL rise_level: got %b want 1", db_level_o);
        end
    endtask

    task automatic test_bounce_high();
        int falls = 0;
        bit lvl_dropped = 0;
        for (int i = 0; i < 100; i++) begin
            drive(i < 60 ? bit'(((i / 3) % 2) == 0) : 1'b1);
            n_vec++;
            if ({db_level_o, db_rise_o, db_fall_o} !== {m_lvl, e_rise, e_fall}) begin
                n_err++;
                $display("FAIL bounce_model cyc %0d: got %b want %b", i,
                         {db_level_o, db_rise_o, db_fall_o}, {m_lvl, e_rise, e_fall});
            end
            if (db_fall_o === 1'b1) falls++;
            if (db_level_o !== 1'b1) lvl_dropped = 1;
        end
        n_vec++;
        if (falls != 0 || lvl_dropped) begin
            n_err++;
            $display("FAIL bounce_hold: falls %0d dropped %0d want 0 0", falls, lvl_dropped);
        end
    endtask

    task automatic test_fall();
        int falls = 0;
        int first = -1;
        int width = 0;
        for (int i = 1; i <= 40; i++) begin
            drive(1'b0);
            n_vec++;
            if ({db_level_o, db_rise_o, db_fall_o} !== {m_lvl, e_rise, e_fall}) begin
                n_err++;
                $display("FAIL fall_model cyc %0d: got %b want %b", i,
                         {db_level_o, db_rise_o, db_fall_o}, {m_lvl, e_rise, e_fall});
            end
            if (db_fall_o === 1'b1) begin
                falls++;
                width++;
                if (first < 0) first = i;
            end
        end
        n_vec++;
        if (falls != 1 || width != 1) begin
            n_err++;
            $display("FAIL fall_pulse: count %0d width %0d want 1 1", falls, width);
        end
        n_vec++;
        if (first < LAT_MIN || first > LAT_MAX) begin
            n_err++;
            $display("FAIL fall_latency: got %0d want %0d..%0d", first, LAT_MIN, LAT_MAX);
        end
        n_vec++;
        if (db_level_o !== 1'b0) begin
            n_err++;
            $display("FAIL fall_level: got %b want 0", db_level_o);
        end
    endtask

    task automatic test_short_pulse();
        int rises = 0;
        for (int i = 0; i < 52; i++) begin
            drive(i < 12 ? 1'b1 : 1'b0);
            n_vec++;
            if ({db_level_o, db_rise_o, db_fall_o} !== {m_lvl, e_rise, e_fall}) begin
                n_err++;
                $display("FAIL short_model cyc %0d: got %b want %b", i,
                         {db_level_o, db_rise_o, db_fall_o}, {m_lvl, e_rise, e_fall});
            end
            if (db_rise_o === 1'b1) rises++;
        end
        n_vec++;
        if (rises != 0 || db_level_o !== 1'b0) begin
            n_err++;
            $display("FAIL short_reject: rises %0d level %b want 0 0", rises, db_level_o);
        end
    endtask

    task automatic test_reset_midwait();
        bit found = 0;
        int first = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            drive(1'b1);
            if (m_pend && m_ticks == 2 && !m_lvl) found = 1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL midwait_reach: got 0 want 1 within 60 cycles");
        end
        #3 rst_i = 1'b1;
        #1;
        n_vec++;
        if ({db_level_o, db_rise_o, db_fall_o} !== 3'b000) begin
            n_err++;
            $display("FAIL midwait_async: got %b want 000", {db_level_o, db_rise_o, db_fall_o});
        end
        @(posedge clk_i);
        #1;
        n_vec++;
        if ({db_level_o, db_rise_o, db_fall_o} !== 3'b000) begin
            n_err++;
            $display("FAIL midwait_held: got %b want 000", {db_level_o, db_rise_o, db_fall_o});
        end
        #3 rst_i = 1'b0;
        model_reset();
        for (int i = 1; i <= 40; i++) begin
            drive(1'b1);
            n_vec++;
            if ({db_level_o, db_rise_o, db_fall_o} !== {m_lvl, e_rise, e_fall}) begin
                n_err++;
                $display("FAIL requal_model cyc %0d: got %b want %b", i,
                         {db_level_o, db_rise_o, db_fall_o}, {m_lvl, e_rise, e_fall});
            end
            if (db_rise_o === 1'b1 && first < 0) first = i;
        end
        n_vec++;
        if (first < LAT_MIN || first > LAT_MAX) begin
            n_err++;
            $display("FAIL requal_latency: got %0d want %0d..%0d", first, LAT_MIN, LAT_MAX);
        end
        // Reset while accepted high must clear the level without a fall pulse.
        #3 rst_i = 1'b1;
        #1;
        n_vec++;
        if ({db_level_o, db_rise_o, db_fall_o} !== 3'b000) begin
            n_err++;
            $display("FAIL one_reset: got %b want 000", {db_level_o, db_rise_o, db_fall_o});
        end
        @(posedge clk_i);
        #4 rst_i = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0);
            n_vec++;
            if ({db_level_o, db_rise_o, db_fall_o} !== 3'b000) begin
                n_err++;
                $display("FAIL one_reset_after cyc %0d: got %b want 000", i,
                         {db_level_o, db_rise_o, db_fall_o});
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 80; r++) begin
            bit val;
            int len;
            if ($urandom_range(0, 19) == 0) begin
                #3 rst_i = 1'b1;
                #1;
                n_vec++;
                if ({db_level_o, db_rise_o, db_fall_o} !== 3'b000) begin
                    n_err++;
                    $display("FAIL rand_reset run %0d: got %b want 000", r,
                             {db_level_o, db_rise_o, db_fall_o});
                end
                @(posedge clk_i);
                #4 rst_i = 1'b0;
                model_reset();
            end
            val = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40))
                                              : int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                drive(val);
                n_vec++;
                if ({db_level_o, db_rise_o, db_fall_o} !== {m_lvl, e_rise, e_fall}) begin
                    n_err++;
                    $display("FAIL rand_model run %0d cyc %0d: got %b want %b", r, i,
                             {db_level_o, db_rise_o, db_fall_o}, {m_lvl, e_rise, e_fall});
                end
                if (db_rise_o === 1'b1 && db_fall_o === 1'b1) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rand_both_pulses run %0d: got 11 want not both", r);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rise();
        test_bounce_high();
        test_fall();
        test_short_pulse();
        test_reset_midwait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
